// File: rtl/bidir_bus_ctrl.sv
// ============================================================================
// Module      : bidir_bus_ctrl
// Description : Turnaround-safe sequencer for a bidirectional IOBUF pad bus
//               arbitrating one write and one read requester.
//               Optional macro BIDIR_BUS_CTRL_SYNC_EN adds a 2-flop pad_i
//               synchronizer and stretches SAMPLE to 3 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bidir_bus_ctrl #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_t,
    input  logic [WIDTH-1:0] pad_i,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_PARK   = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    localparam logic [3:0] c_hold = (HOLD_CYCLES < 1) ? 4'd1 : HOLD_CYCLES[3:0];
    localparam logic [3:0] c_turn = (TURN_CYCLES < 1) ? 4'd1 : TURN_CYCLES[3:0];
`ifdef BIDIR_BUS_CTRL_SYNC_EN
    localparam logic [3:0] c_sample = 4'd3;
`else
    localparam logic [3:0] c_sample = 4'd1;
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_cnt;
    logic [3:0]       w_next_cnt;
    logic             r_drive;
    logic             r_prio_wr;
    logic [WIDTH-1:0] r_pad_o;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             w_wr_ready;
    logic             w_rd_ready;
    logic             w_capture;
    logic             w_last;
    logic [WIDTH-1:0] w_sample_src;

`ifdef BIDIR_BUS_CTRL_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample_src = r_sync2;
`else
    assign w_sample_src = pad_i;
`endif

    // A zero count can only follow reset; treat it as the final cycle.
    assign w_last = (r_cnt <= 4'd1);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_wr_ready   = 1'b0;
        w_rd_ready   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wr_valid && (!rd_valid || r_prio_wr)) begin
                    w_wr_ready   = 1'b1;
                    w_next_state = ST_DRIVE;
                    w_next_cnt   = c_hold;
                end else if (rd_valid) begin
                    w_rd_ready   = 1'b1;
                    w_next_state = ST_SAMPLE;
                    w_next_cnt   = c_sample;
                end
            end
            ST_DRIVE: begin
                if (!w_last) begin
                    w_next_cnt = r_cnt - 4'd1;
                end else if (wr_valid && !rd_valid) begin
                    // Streaming write: keep driving without a park gap.
                    w_wr_ready = 1'b1;
                    w_next_cnt = c_hold;
                end else begin
                    w_next_state = ST_PARK;
                    w_next_cnt   = c_turn;
                end
            end
            ST_PARK: begin
                if (w_last) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (w_last) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_IDLE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_drive     <= 1'b0;
            r_prio_wr   <= 1'b1;
            r_pad_o     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_drive     <= (w_next_state == ST_DRIVE);
            r_rsp_valid <= w_capture;
            if (w_wr_ready) begin
                r_pad_o   <= wr_data;
                r_prio_wr <= 1'b0;
            end else if (w_rd_ready) begin
                r_prio_wr <= 1'b1;
            end
            if (w_capture) begin
                r_rsp_data <= w_sample_src;
            end
        end
    end

    assign wr_ready  = w_wr_ready;
    assign rd_ready  = w_rd_ready;
    assign pad_t     = {WIDTH{~r_drive}};
    assign pad_o     = r_pad_o;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bidir_bus_ctrl.sv
// ============================================================================
// Module      : tb_bidir_bus_ctrl
// Description : Self-checking bench for bidir_bus_ctrl using a timeline model
//               (absolute cycle windows for drive, idle and response).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bidir_bus_ctrl;

    localparam int W = 8;
    localparam int H = 2;
    localparam int T = 2;
`ifdef BIDIR_BUS_CTRL_SYNC_EN
    localparam int L = 3;
    localparam int S = 1;
`else
    localparam int L = 1;
    localparam int S = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [W-1:0] wr_data = '0;
    logic         rd_valid = 1'b0;
    logic         rd_ready;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic [W-1:0] pad_o;
    logic [W-1:0] pad_t;
    logic [W-1:0] pad_i = '0;
    logic         busy;

    bidir_bus_ctrl #(.WIDTH(W), .HOLD_CYCLES(H), .TURN_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .pad_o(pad_o), .pad_t(pad_t), .pad_i(pad_i), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference timeline: windows expressed in absolute cycle numbers.
    int       m_idle_from = 1;
    int       m_drive_first = 1 << 30;
    int       m_drive_last = -1;
    int       m_rsp_cycle = -1;
    logic     m_prio_w = 1'b1;
    logic [W-1:0] m_pad_o = '0;
    logic [W-1:0] m_rsp_data = '0;
    logic [W-1:0] pad_hist [0:8191];

    logic         e_wr_ready, e_rd_ready, e_busy, e_rsp_valid, e_idle;
    logic [W-1:0] e_pad_t, e_pad_o, e_rsp_data;

    task automatic eval_model();
        @(negedge clk);
        pad_hist[cyc] = pad_i;
        e_idle     = (cyc >= m_idle_from);
        e_wr_ready = e_idle ? (wr_valid && (!rd_valid || m_prio_w))
                            : (cyc == m_drive_last && wr_valid && !rd_valid);
        e_rd_ready = e_idle && rd_valid && (!wr_valid || !m_prio_w);
        e_busy     = !e_idle;
        e_pad_t    = (cyc >= m_drive_first && cyc <= m_drive_last) ? '0 : '1;
        e_pad_o    = m_pad_o;
        e_rsp_valid = (cyc == m_rsp_cycle);
        if (e_rsp_valid) m_rsp_data = pad_hist[m_rsp_cycle - 1 - 2 * S];
        e_rsp_data = m_rsp_data;
    endtask

    task automatic advance();
        if (reset) begin
            m_idle_from   = cyc + 1;
            m_drive_first = 1 << 30;
            m_drive_last  = -1;
            m_rsp_cycle   = -1;
            m_prio_w      = 1'b1;
            m_pad_o       = '0;
            m_rsp_data    = '0;
        end else if (e_wr_ready) begin
            if (e_idle) m_drive_first = cyc + 1;
            m_drive_last = cyc + H;
            m_idle_from  = cyc + H + T + 1;
            m_pad_o      = wr_data;
            m_prio_w     = 1'b0;
        end else if (e_rd_ready) begin
            m_idle_from = cyc + L + 1;
            m_rsp_cycle = cyc + L + 1;
            m_prio_w    = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle();
        int k;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        for (k = 0; k < 50; k++) begin
            eval_model();
            if (!busy) break;
            advance();
        end
        n_vec++;
        if (k >= 50) begin
            n_err++;
            $display("FAIL wait_idle: busy still %b after 50 cycles, required 0", busy);
        end
        advance();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin eval_model(); advance(); end
        reset = 1'b0;
        eval_model();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_vec++; if (pad_t !== 8'hFF) begin n_err++; $display("FAIL reset_pad_t: got %h required ff", pad_t); end
        n_vec++; if (pad_o !== 8'h00) begin n_err++; $display("FAIL reset_pad_o: got %h required 00", pad_o); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_vec++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data: got %h required 00", rsp_data); end
        advance();
    endtask

    task automatic test_single_write();
        wr_valid = 1'b1; wr_data = 8'hA5; rd_valid = 1'b0;
        eval_model();
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL sw_grant: got %b required 1", wr_ready); end
        advance();
        wr_valid = 1'b0;
        for (int k = 0; k < H; k++) begin
            eval_model();
            n_vec++; if (pad_t !== 8'h00 || pad_o !== 8'hA5)
                begin n_err++; $display("FAIL sw_drive[%0d]: got t=%h o=%h required t=00 o=a5", k, pad_t, pad_o); end
            advance();
        end
        for (int k = 0; k < T; k++) begin
            eval_model();
            n_vec++; if (pad_t !== 8'hFF || pad_o !== 8'hA5 || busy !== 1'b1)
                begin n_err++; $display("FAIL sw_park[%0d]: got t=%h o=%h busy=%b required t=ff o=a5 busy=1", k, pad_t, pad_o, busy); end
            advance();
        end
        eval_model();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sw_idle: busy got %b required 0", busy); end
        advance();
    endtask

    task automatic test_read();
        pad_i = 8'h3C; rd_valid = 1'b1;
        eval_model();
        n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL rd_grant: got %b required 1", rd_ready); end
        advance();
        rd_valid = 1'b0;
        for (int k = 1; k <= L; k++) begin
            eval_model();
            n_vec++; if (rsp_valid !== 1'b0 || pad_t !== 8'hFF)
                begin n_err++; $display("FAIL rd_wait[N+%0d]: got rsp_valid=%b t=%h required 0 ff", k, rsp_valid, pad_t); end
            advance();
        end
        eval_model();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || busy !== 1'b0)
            begin n_err++; $display("FAIL rd_rsp: got v=%b d=%h busy=%b required 1 3c 0", rsp_valid, rsp_data, busy); end
        advance();
        eval_model();
        n_vec++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h3C)
            begin n_err++; $display("FAIL rd_hold: got v=%b d=%h required 0 3c", rsp_valid, rsp_data); end
        advance();
    endtask

    task automatic test_alternate();
        int last_side = -1;
        int grants = 0;
        int bad = 0;
        reset = 1'b1; eval_model(); advance(); reset = 1'b0;
        wr_valid = 1'b1; rd_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            wr_data = 8'($urandom);
            pad_i   = 8'($urandom);
            eval_model();
            if (wr_ready && rd_ready) bad++;
            if (wr_ready || rd_ready) begin
                if (grants == 0 && !wr_ready) bad++;
                if (last_side == (wr_ready ? 1 : 0)) bad++;
                last_side = wr_ready ? 1 : 0;
                grants++;
            end
            if (pad_t !== e_pad_t) bad++;
            advance();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL alternate: got %0d grant/pad_t violations required 0", bad); end
        n_vec++; if (grants < 8) begin n_err++; $display("FAIL alternate_count: got %0d grants required >=8", grants); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        logic [W-1:0] seen [$];
        int idx = 0, n_low = 0, first_low = -1, last_low = -1, park = 0, done = 0, bad = 0;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        rd_valid = 1'b0;
        for (int k = 0; k < 60 && done == 0; k++) begin
            wr_valid = (idx < 3);
            wr_data  = (idx < 3) ? words[idx] : 8'h00;
            eval_model();
            if (pad_t == 8'h00) begin
                n_low++;
                if (first_low < 0) first_low = cyc;
                last_low = cyc;
                seen.push_back(pad_o);
            end else if (busy && n_low > 0) begin
                park++;
            end
            if (!busy && idx == 3 && n_low > 0) done = 1;
            if (wr_valid && wr_ready) idx++;
            advance();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < seen.size() && i < 3 * H; i++)
            if (seen[i] !== words[i / H]) bad++;
        n_vec++; if (n_low !== 3 * H) begin n_err++; $display("FAIL b2b_drive_len: got %0d required %0d", n_low, 3 * H); end
        n_vec++; if (last_low - first_low + 1 !== n_low) begin n_err++; $display("FAIL b2b_contiguous: got span %0d for %0d cycles", last_low - first_low + 1, n_low); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_words: got %0d wrong words required 0", bad); end
        n_vec++; if (park !== T) begin n_err++; $display("FAIL b2b_park: got %0d required %0d", park, T); end
        n_vec++; if (done !== 1) begin n_err++; $display("FAIL b2b_timeout: got done=%0d required 1", done); end
    endtask

    task automatic test_write_then_read();
        int drive_n = 0, park_n = 0, early_w = 0, got = 0, k;
        logic rgrant = 1'b0;
        logic [W-1:0] val = '0;
        pad_i = 8'h5A; wr_valid = 1'b1; wr_data = 8'hC3; rd_valid = 1'b0;
        eval_model();
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wtr_grant: got %b required 1", wr_ready); end
        advance();
        wr_data = 8'h77; rd_valid = 1'b1;
        for (k = 0; k < 40 && got == 0; k++) begin
            eval_model();
            if (pad_t == 8'h00) drive_n++;
            else if (busy && !rgrant) park_n++;
            if (wr_ready && !rgrant) early_w++;
            if (rsp_valid) begin got = 1; val = rsp_data; end
            if (rd_ready) rgrant = 1'b1;
            advance();
            if (rgrant) rd_valid = 1'b0;
        end
        wr_valid = 1'b0;
        n_vec++; if (drive_n !== H) begin n_err++; $display("FAIL wtr_drive: got %0d required %0d", drive_n, H); end
        n_vec++; if (park_n !== T) begin n_err++; $display("FAIL wtr_park: got %0d required %0d", park_n, T); end
        n_vec++; if (early_w !== 0) begin n_err++; $display("FAIL wtr_read_first: got %0d early writes required 0", early_w); end
        n_vec++; if (got !== 1 || val !== 8'h5A) begin n_err++; $display("FAIL wtr_rsp: got seen=%0d data=%h required 1 5a", got, val); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        wr_valid = 1'b1; wr_data = 8'h96;
        eval_model(); advance();
        wr_valid = 1'b0; reset = 1'b1;
        eval_model();
        n_vec++; if (pad_t !== 8'h00) begin n_err++; $display("FAIL rstw_drive: got %h required 00", pad_t); end
        advance();
        reset = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
        eval_model();
        n_vec++; if (pad_t !== 8'hFF || busy !== 1'b0 || rsp_valid !== 1'b0)
            begin n_err++; $display("FAIL rstw_state: got t=%h busy=%b v=%b required ff 0 0", pad_t, busy, rsp_valid); end
        n_vec++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0)
            begin n_err++; $display("FAIL rstw_prio: got w=%b r=%b required 1 0", wr_ready, rd_ready); end
        advance();
        wait_idle();
        rd_valid = 1'b1;
        eval_model(); advance();
        rd_valid = 1'b0; reset = 1'b1;
        eval_model(); advance();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            eval_model();
            n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstr_no_rsp[%0d]: got %b required 0", k, rsp_valid); end
            advance();
        end
    endtask

    task automatic test_random();
        logic w_fired = 1'b0, r_fired = 1'b0;
        for (int k = 0; k < 900; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!wr_valid || w_fired) begin
                wr_valid = ($urandom_range(0, 2) != 0);
                wr_data  = 8'($urandom);
            end
            if (!rd_valid || r_fired) rd_valid = ($urandom_range(0, 2) == 0);
            pad_i = 8'($urandom);
            eval_model();
            n_vec++; if (wr_ready !== e_wr_ready || rd_ready !== e_rd_ready)
                begin n_err++; $display("FAIL rnd_grant@%0d: got w=%b r=%b required %b %b", cyc, wr_ready, rd_ready, e_wr_ready, e_rd_ready); end
            n_vec++; if (pad_t !== e_pad_t || pad_o !== e_pad_o)
                begin n_err++; $display("FAIL rnd_pad@%0d: got t=%h o=%h required %h %h", cyc, pad_t, pad_o, e_pad_t, e_pad_o); end
            n_vec++; if (busy !== e_busy)
                begin n_err++; $display("FAIL rnd_busy@%0d: got %b required %b", cyc, busy, e_busy); end
            n_vec++; if (rsp_valid !== e_rsp_valid || rsp_data !== e_rsp_data)
                begin n_err++; $display("FAIL rnd_rsp@%0d: got v=%b d=%h required %b %h", cyc, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data); end
            w_fired = wr_valid && wr_ready;
            r_fired = rd_valid && rd_ready;
            advance();
        end
        reset = 1'b0;
        wait_idle();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_read();
        test_alternate();
        test_back_to_back();
        test_write_then_read();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
